// File: rtl/uart_pkg.sv
// Shared UART types: receive FIFO entry layout and the RTS flow-control states.
package uart_pkg;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [8:0] word;
    } uart_rx_entry_t;

    typedef enum logic {
        RTS_OFF = 1'b0,
        RTS_ON  = 1'b1
    } uart_rts_state_e;

    localparam int UART_RX_ENTRY_W = $bits(uart_rx_entry_t);

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on o_rdata whenever not empty.
module uart_sync_fifo #(
    parameter  int WIDTH = 11,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push != w_pop) r_level <= w_push ? r_level + 1'b1 : r_level - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_level = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers characters from uart_rx, drives RTS from the
// FIFO fill level, and keeps sticky error status plus an interrupt request.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int RTS_HIGH_WM = 6,
    parameter  int RTS_LOW_WM  = 2,
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_hw_flow_control_enable,
    input  logic          i_rx_done,
    input  logic [8:0]    i_rx_word,
    input  logic          i_rx_frame_error,
    input  logic          i_rx_parity_error,
    output logic          o_rts_n,
    output logic          o_data_valid,
    output logic [8:0]    o_data,
    output logic [1:0]    o_data_err,
    input  logic          i_data_ready,
    output logic [LW-1:0] o_level,
    output logic          o_overrun,
    output logic          o_frame_err,
    output logic          o_parity_err,
    input  logic          i_status_clear,
    output logic          o_irq
);

    localparam logic [LW-1:0] HIGH_WM = LW'(RTS_HIGH_WM);
    localparam logic [LW-1:0] LOW_WM  = LW'(RTS_LOW_WM);

    uart_rx_entry_t  w_wr_entry;
    uart_rx_entry_t  w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_valid;
    logic            w_pop;
    logic            w_drop;
    logic [LW-1:0]   w_level;
    uart_rts_state_e r_state;
    uart_rts_state_e w_state_nxt;
    logic            r_rts_n;
    logic            r_overrun;
    logic            r_frame_err;
    logic            r_parity_err;
    logic            r_irq;

    assign w_wr_entry = '{frame_err: i_rx_frame_error, parity_err: i_rx_parity_error, word: i_rx_word};

    uart_sync_fifo #(
        .WIDTH (UART_RX_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (i_rx_done),
        .i_wdata (w_wr_entry),
        .i_pop   (i_data_ready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_valid = ~w_empty;
    assign w_pop   = w_valid & i_data_ready;
    assign w_drop  = i_rx_done & w_full & ~w_pop;

    // Error flags are recorded even for dropped characters; a new set wins over clear.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_overrun    <= w_drop | (r_overrun & ~i_status_clear);
            r_frame_err  <= (i_rx_done & i_rx_frame_error) | (r_frame_err & ~i_status_clear);
            r_parity_err <= (i_rx_done & i_rx_parity_error) | (r_parity_err & ~i_status_clear);
            r_irq        <= w_valid | r_overrun | r_frame_err | r_parity_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RTS_OFF: if (!i_hw_flow_control_enable || w_level <= LOW_WM) w_state_nxt = RTS_ON;
            RTS_ON:  if (i_hw_flow_control_enable && w_level >= HIGH_WM) w_state_nxt = RTS_OFF;
        endcase
    end

    // RTS is decoded from the next state so it moves on the same edge as the FSM.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= RTS_OFF;
            r_rts_n <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_rts_n <= (w_state_nxt == RTS_OFF);
        end
    end

    assign o_rts_n      = r_rts_n;
    assign o_data_valid = w_valid;
    assign o_data       = w_valid ? w_head.word : '0;
    assign o_data_err   = w_valid ? {w_head.frame_err, w_head.parity_err} : 2'b00;
    assign o_level      = w_level;
    assign o_overrun    = r_overrun;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_irq        = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a queue-level model predicts FIFO contents,
// flags, IRQ and RTS; a negedge monitor compares and pops on each handshake.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int HI    = 6;
    localparam int LO    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       fc = 1'b1;
    logic       rx_done = 1'b0;
    logic [8:0] rx_word = '0;
    logic       rx_fe = 1'b0;
    logic       rx_pe = 1'b0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;

    logic       o_rts_n;
    logic       o_data_valid;
    logic [8:0] o_data;
    logic [1:0] o_data_err;
    logic [3:0] o_level;
    logic       o_overrun;
    logic       o_frame_err;
    logic       o_parity_err;
    logic       o_irq;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [10:0] sb[$];
    int          m_level = 0;
    int          lvl0;
    bit          m_ov = 0, m_fe = 0, m_pe = 0, m_irq = 0, m_rts_n = 1;
    bit          m_pop, m_acc;

    uart_rx_ctrl #(.DEPTH(DEPTH), .RTS_HIGH_WM(HI), .RTS_LOW_WM(LO)) dut (
        .i_clk                    (clk),
        .i_nrst                   (rst_n),
        .i_hw_flow_control_enable (fc),
        .i_rx_done                (rx_done),
        .i_rx_word                (rx_word),
        .i_rx_frame_error         (rx_fe),
        .i_rx_parity_error        (rx_pe),
        .o_rts_n                  (o_rts_n),
        .o_data_valid             (o_data_valid),
        .o_data                   (o_data),
        .o_data_err               (o_data_err),
        .i_data_ready             (rdy),
        .o_level                  (o_level),
        .o_overrun                (o_overrun),
        .o_frame_err              (o_frame_err),
        .o_parity_err             (o_parity_err),
        .i_status_clear           (clr),
        .o_irq                    (o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = 0; sb.delete();
            m_ov = 0; m_fe = 0; m_pe = 0; m_irq = 0; m_rts_n = 1;
        end else begin
            lvl0  = m_level;
            m_irq = (lvl0 > 0) | m_ov | m_fe | m_pe;
            if (!fc)            m_rts_n = 0;
            else if (lvl0 >= HI) m_rts_n = 1;
            else if (lvl0 <= LO) m_rts_n = 0;
            m_pop = rdy && (lvl0 > 0);
            m_acc = rx_done && ((lvl0 < DEPTH) || m_pop);
            m_ov  = (rx_done && !m_acc) || (m_ov && !clr);
            m_fe  = (rx_done && rx_fe) || (m_fe && !clr);
            m_pe  = (rx_done && rx_pe) || (m_pe && !clr);
            if (m_acc) sb.push_back({rx_fe, rx_pe, rx_word});
            m_level = lvl0 + int'(m_acc) - int'(m_pop);
        end
    end

    always @(negedge clk) begin
        chk("level", o_level, m_level);
        chk("valid", o_data_valid, m_level > 0);
        chk("rts_n", o_rts_n, m_rts_n);
        chk("irq", o_irq, m_irq);
        chk("overrun", o_overrun, m_ov);
        chk("frame_err", o_frame_err, m_fe);
        chk("parity_err", o_parity_err, m_pe);
        if (o_data_valid) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                chk("head", {o_data_err, o_data}, sb[0]);
                if (rdy) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic d, input logic [8:0] w, input logic f, input logic p,
                        input logic r, input logic c);
        rx_done = d; rx_word = w; rx_fe = f; rx_pe = p; rdy = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        step(1'b0, 9'h000, 1'b0, 1'b0, r, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && o_level != 0; k++) idle(1'b1);
        chk("drain_empty", o_level, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rts_n", o_rts_n, 1);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_irq", o_irq, 0);
        chk("rst_flags", {o_overrun, o_frame_err, o_parity_err}, 0);
        chk("rst_data", {o_data_err, o_data}, 0);
        rst_n = 1'b1;
        idle(1'b0);
        chk("rts_first_cycle", o_rts_n, 0);

        // Single character
        step(1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_valid", o_data_valid, 1);
        chk("single_data", o_data, 9'h0A5);
        chk("single_level", o_level, 1);
        chk("single_irq_early", o_irq, 0);
        idle(1'b0);
        chk("single_irq", o_irq, 1);
        idle(1'b1);

        // Watermark hysteresis
        for (int i = 0; i < 6; i++) step(1'b1, 9'(i + 16), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hw_level", o_level, 6);
        chk("hw_rts_lag", o_rts_n, 0);
        idle(1'b0);
        chk("hw_rts_off", o_rts_n, 1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("lw_level", o_level, 2);
        chk("lw_rts_lag", o_rts_n, 1);
        idle(1'b0);
        chk("lw_rts_on", o_rts_n, 0);
        drain();

        // Overrun: ninth character dropped
        idle(1'b0);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 9'(9'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_level", o_level, 8);
        chk("ovr_flag", o_overrun, 1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("ovr_drained", o_level, 0);

        // Full with simultaneous push and pop
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 9'(9'h0C0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_pp_level", o_level, 8);
        chk("full_pp_ovr", o_overrun, 0);
        for (int i = 0; i < 7; i++) idle(1'b1);
        chk("full_pp_last", o_data, 9'h1FF);
        idle(1'b1);

        // Clear colliding with a new parity error
        step(1'b1, 9'h033, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h044, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_frame", o_frame_err, 0);
        chk("clr_parity", o_parity_err, 1);
        chk("err_head0", o_data_err, 2'b10);
        idle(1'b1);
        chk("err_head1", o_data_err, 2'b01);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int rp;
            rp = (i < 1500) ? 70 : 25;
            if ($urandom_range(0, 199) == 0) fc = ~fc;
            step($urandom_range(0, 99) < 55, 9'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 99) < rp, $urandom_range(0, 63) == 0);
        end

        // Flow control disabled, then asynchronous reset mid-stream
        fc = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 9'(9'h080 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk("nofc_rts", o_rts_n, 0);
        end
        chk("nofc_level", o_level, 8);
        rx_done = 1'b1; rx_word = 9'h155; rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", o_level, 0);
        chk("arst_rts_n", o_rts_n, 1);
        chk("arst_valid", o_data_valid, 0);
        rx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1'b0);
        chk("post_rst_rts", o_rts_n, 0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
